// File: rtl/oled_pkg.sv
// oled_pkg: shared constants for the OLED text streamer (byte width, blank character, FSM encoding).
package oled_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] ASCII_SPACE = 8'h20;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_SEND   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/oled_text_buffer.sv
// oled_text_buffer: character RAM that fills with INIT_CHAR on reset.
// Synchronous write port, combinational read so the streamer samples a byte in the cycle it leaves LOAD.
module oled_text_buffer
  import oled_pkg::*;
#(
  parameter int                DEPTH     = 64,
  parameter int                ADDR_W    = 6,
  parameter logic [BYTE_W-1:0] INIT_CHAR = ASCII_SPACE
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [BYTE_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [BYTE_W-1:0] rd_data_o
);

  logic [BYTE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT_CHAR;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/oled_text_streamer.sv
// oled_text_streamer: writable text buffer streamed byte-by-byte to the OLED interface (full frame or one line).
// Build option OLED_STREAMER_AUTOREFRESH_EN: any buffer write schedules an automatic full-frame refresh.
module oled_text_streamer
  import oled_pkg::*;
#(
  parameter int                NUM_LINES      = 4,
  parameter int                CHARS_PER_LINE = 16,
  parameter logic [BYTE_W-1:0] INIT_CHAR      = ASCII_SPACE,
  parameter int ADDR_W = (NUM_LINES * CHARS_PER_LINE > 1) ? $clog2(NUM_LINES * CHARS_PER_LINE) : 1,
  parameter int LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              start,
  input  logic              mode,
  input  logic [LINE_W-1:0] line_sel,
  output logic              busy,
  output logic              frame_done,
  output logic              start_err,
  output logic [BYTE_W-1:0] send_data,
  output logic              send_valid,
  input  logic              send_done
);

  localparam int              DEPTH     = NUM_LINES * CHARS_PER_LINE;
  localparam logic [ADDR_W:0] DEPTH_A   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_FULL = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CPL       = (ADDR_W + 1)'(CHARS_PER_LINE);
  localparam logic [ADDR_W:0] CPL_M1    = (ADDR_W + 1)'(CHARS_PER_LINE - 1);
  localparam logic [LINE_W:0] LINES_L   = (LINE_W + 1)'(NUM_LINES);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]   last_q, last_d;
  logic              busy_q, busy_d;
  logic              start_err_q, start_err_d;
  logic [BYTE_W-1:0] send_data_q, send_data_d;
  logic              send_valid_q, send_valid_d;

  logic              wr_accept;
  logic              line_ok;
  logic [ADDR_W:0]   line_first;
  logic [BYTE_W-1:0] rd_data;
  logic              launch;
  logic              auto_go;

  // Out-of-range writes are dropped here so neither the RAM nor the dirty flag sees them.
  assign wr_accept  = wr_en && ({1'b0, wr_addr} < DEPTH_A);
  assign line_ok    = ({1'b0, line_sel} < LINES_L);
  assign line_first = (ADDR_W + 1)'(line_sel) * CPL;

  oled_text_buffer #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_CHAR (INIT_CHAR)
  ) u_buf (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (ptr_q[ADDR_W-1:0]),
    .rd_data_o (rd_data)
  );

`ifdef OLED_STREAMER_AUTOREFRESH_EN
  logic dirty_q;

  // A write in the same cycle as a launch wins, so that data still gets its own refresh.
  always_ff @(posedge CLOCK) begin
    if (RESET)          dirty_q <= 1'b0;
    else if (wr_accept) dirty_q <= 1'b1;
    else if (launch)    dirty_q <= 1'b0;
  end

  assign auto_go = dirty_q;
`else
  assign auto_go = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    last_d       = last_q;
    busy_d       = busy_q;
    start_err_d  = 1'b0;
    send_data_d  = send_data_q;
    send_valid_d = send_valid_q;
    launch       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (!mode || line_ok)) begin
          launch = 1'b1;
          ptr_d  = mode ? line_first : '0;
          last_d = mode ? (line_first + CPL_M1) : LAST_FULL;
        end else if (start) begin
          start_err_d = 1'b1;
        end else if (auto_go) begin
          launch = 1'b1;
          ptr_d  = '0;
          last_d = LAST_FULL;
        end
        if (launch) begin
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Wait for the interface to release the previous byte's done level.
        if (!send_done) begin
          send_data_d  = rd_data;
          send_valid_d = 1'b1;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (send_done) begin
          send_valid_d = 1'b0;
          if (ptr_q == last_q) begin
            state_d = ST_FINISH;
          end else begin
            ptr_d   = ptr_q + (ADDR_W + 1)'(1);
            state_d = ST_LOAD;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      last_q       <= '0;
      busy_q       <= 1'b0;
      start_err_q  <= 1'b0;
      send_data_q  <= '0;
      send_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      start_err_q  <= start_err_d;
      send_data_q  <= send_data_d;
      send_valid_q <= send_valid_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = (state_q == ST_FINISH);
  assign start_err  = start_err_q;
  assign send_data  = send_data_q;
  assign send_valid = send_valid_q;

endmodule

// File: tb/tb_oled_text_streamer.sv
// Bench for oled_text_streamer: a 4x16 instance with a delayed-ack OLED model and a 3x5 instance for range edges.
// The OLED_STREAMER_AUTOREFRESH_EN macro selects which refresh behaviour is expected.
module tb_oled_text_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, wr_en, start, mode, busy, frame_done, start_err, send_valid, send_done;
  logic [5:0] wr_addr;
  logic [7:0] wr_data, send_data;
  logic [1:0] line_sel;

  logic       wr_en_b, start_b, mode_b, busy_b, frame_done_b, start_err_b, send_valid_b, send_done_b;
  logic [3:0] wr_addr_b;
  logic [7:0] wr_data_b, send_data_b;
  logic [1:0] line_sel_b;

  oled_text_streamer dut (
    .CLOCK(clk), .RESET(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .mode(mode), .line_sel(line_sel), .busy(busy), .frame_done(frame_done),
    .start_err(start_err), .send_data(send_data), .send_valid(send_valid), .send_done(send_done)
  );

  oled_text_streamer #(.NUM_LINES(3), .CHARS_PER_LINE(5)) dut_b (
    .CLOCK(clk), .RESET(rst), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .start(start_b), .mode(mode_b), .line_sel(line_sel_b), .busy(busy_b), .frame_done(frame_done_b),
    .start_err(start_err_b), .send_data(send_data_b), .send_valid(send_valid_b), .send_done(send_done_b)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] model_a [64];
  logic [7:0] model_b [15];
  logic [7:0] cap_a [$];
  logic [7:0] cap_b [$];
  int  fd_a = 0, fd_b = 0, se_a = 0, se_b = 0;
  int  ack_cnt = 0;
  bit  ack_en = 1'b1;
  bit  prev_va = 1'b0, prev_vb = 1'b0;

  // OLED interface model and output monitor: done rises two cycles after a request, drops once it is released.
  always @(negedge clk) begin
    if (send_valid && !prev_va) cap_a.push_back(send_data);
    prev_va = send_valid;
    if (frame_done) fd_a++;
    if (start_err) se_a++;
    if (ack_en) begin
      if (send_valid && !send_done) begin
        ack_cnt++;
        if (ack_cnt >= 2) begin
          send_done = 1'b1;
          ack_cnt = 0;
        end
      end else if (!send_valid) begin
        send_done = 1'b0;
        ack_cnt = 0;
      end
    end
    if (send_valid_b && !prev_vb) cap_b.push_back(send_data_b);
    prev_vb = send_valid_b;
    if (frame_done_b) fd_b++;
    if (start_err_b) se_b++;
    send_done_b = send_valid_b;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = 6'(a); wr_data = d;
    step();
    wr_en = 1'b0;
    model_a[a] = d;
  endtask

  task automatic write_b(input int a, input logic [7:0] d);
    wr_en_b = 1'b1; wr_addr_b = 4'(a); wr_data_b = d;
    step();
    wr_en_b = 1'b0;
    if (a < 15) model_b[a] = d;
  endtask

  task automatic start_a(input logic m, input int l);
    start = 1'b1; mode = m; line_sel = 2'(l);
    step();
    start = 1'b0;
  endtask

  task automatic start_bb(input logic m, input int l);
    start_b = 1'b1; mode_b = m; line_sel_b = 2'(l);
    step();
    start_b = 1'b0;
  endtask

  task automatic settle();
    int quiet = 0;
    for (int i = 0; i < 3000 && quiet < 4; i++) begin
      step();
      quiet = (busy || busy_b) ? 0 : quiet + 1;
    end
    cap_a.delete();
    cap_b.delete();
  endtask

  task automatic wait_frame_a(input int bound, output bit seen, output bit busy_ok);
    seen = 1'b0; busy_ok = 1'b1;
    for (int i = 0; i < bound && !seen; i++) begin
      if (!busy) busy_ok = 1'b0;
      if (frame_done) seen = 1'b1;
      else step();
    end
  endtask

  task automatic wait_frame_b(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      if (frame_done_b) seen = 1'b1;
      else step();
    end
  endtask

  task automatic wait_bytes_a(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (cap_a.size() >= n) ok = 1'b1;
      else step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    vectors++;
    if ({busy, frame_done, start_err, send_valid} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy/fd/err/valid=%b required 0000", {busy, frame_done, start_err, send_valid});
    end
    vectors++;
    if (send_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: send_data=%h required 00", send_data);
    end
    vectors++;
    if ({busy_b, start_err_b, send_valid_b} !== 3'b0) begin
      miscompares++;
      $display("FAIL reset_b: busy/err/valid=%b required 000", {busy_b, start_err_b, send_valid_b});
    end
    rst = 1'b0;
    repeat (2) step();
    vectors++;
    if ({busy, send_valid, frame_done} !== 3'b0) begin
      miscompares++;
      $display("FAIL reset_release: busy/valid/fd=%b required 000", {busy, send_valid, frame_done});
    end
  endtask

  task automatic test_full();
    bit seen, bok;
    int fd0;
    settle();
    fd0 = fd_a;
    start_a(1'b0, 0);
    vectors++;
    if (send_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_n1: send_valid=%b required 0", send_valid);
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_on_start: busy=%b required 1", busy);
    end
    step();
    vectors++;
    if (send_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_n2: send_valid=%b required 1", send_valid);
    end
    wait_frame_a(1000, seen, bok);
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL full_timeout: frame_done=0 required 1");
    end
    step(); step();
    vectors++;
    if (fd_a - fd0 != 1 || cap_a.size() != 64) begin
      miscompares++;
      $display("FAIL full_count: frame_done x%0d bytes %0d required x1 bytes 64", fd_a - fd0, cap_a.size());
    end
    for (int i = 0; i < 64 && i < cap_a.size(); i++) begin
      vectors++;
      if (cap_a[i] !== model_a[i]) begin
        miscompares++;
        $display("FAIL full_byte[%0d]: got %h required %h", i, cap_a[i], model_a[i]);
      end
    end
  endtask

  task automatic test_line();
    bit seen, bok;
    int fd0, l;
    write_a(16, 8'h48);
    write_a(17, 8'h49);
    for (int r = 0; r < 4; r++) begin
      if (r > 0) repeat (4) write_a($urandom_range(0, 63), 8'($urandom));
      l = (r == 0) ? 1 : $urandom_range(0, 3);
      settle();
      fd0 = fd_a;
      start_a(1'b1, l);
      wait_frame_a(500, seen, bok);
      vectors++;
      if (!seen || !bok) begin
        miscompares++;
        $display("FAIL line%0d_frame: done=%b busy_held=%b required 1 1", l, seen, bok);
      end
      step(); step();
      vectors++;
      if (fd_a - fd0 != 1 || cap_a.size() != 16) begin
        miscompares++;
        $display("FAIL line%0d_count: frame_done x%0d bytes %0d required x1 bytes 16", l, fd_a - fd0, cap_a.size());
      end
      for (int i = 0; i < 16 && i < cap_a.size(); i++) begin
        vectors++;
        if (cap_a[i] !== model_a[l * 16 + i]) begin
          miscompares++;
          $display("FAIL line%0d_byte[%0d]: got %h required %h", l, i, cap_a[i], model_a[l * 16 + i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit seen, bok, ok;
    int fd0, se0;
    logic [7:0] v;
    settle();
    fd0 = fd_a; se0 = se_a;
    start_a(1'b0, 0);
    wait_bytes_a(5, ok);
    v = 8'($urandom);
    wr_en = 1'b1; wr_addr = 6'd63; wr_data = v;
    start = 1'b1; mode = 1'b1; line_sel = 2'd2;
    step();
    wr_en = 1'b0; start = 1'b0;
    model_a[63] = v;
    for (int f = 0; f < 2; f++) begin
      wait_frame_a(1000, seen, bok);
      vectors++;
      if (!seen || cap_a.size() != 64) begin
        miscompares++;
        $display("FAIL b2b%0d_frame: done=%b bytes %0d required 1 64", f, seen, cap_a.size());
      end
      for (int i = 0; i < 64 && i < cap_a.size(); i++) begin
        vectors++;
        if (cap_a[i] !== model_a[i]) begin
          miscompares++;
          $display("FAIL b2b%0d_byte[%0d]: got %h required %h", f, i, cap_a[i], model_a[i]);
        end
      end
      cap_a.delete();
      step();
      if (f == 0) start_a(1'b0, 0);
    end
    step();
    vectors++;
    if (fd_a - fd0 != 2 || se_a != se0) begin
      miscompares++;
      $display("FAIL b2b_pulses: frame_done x%0d start_err x%0d required x2 x0", fd_a - fd0, se_a - se0);
    end
  endtask

  task automatic test_done_held();
    bit seen, bok;
    int early = 0;
    settle();
    ack_en = 1'b0;
    send_done = 1'b1;
    step();
    start_a(1'b1, 2);
    repeat (5) begin
      if (send_valid) early++;
      step();
    end
    vectors++;
    if (early != 0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL held_wait: valid cycles %0d busy %b required 0 1", early, busy);
    end
    send_done = 1'b0;
    step();
    vectors++;
    if (send_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL held_release: send_valid=%b required 1", send_valid);
    end
    ack_en = 1'b1;
    wait_frame_a(500, seen, bok);
    vectors++;
    if (!seen || cap_a.size() != 16) begin
      miscompares++;
      $display("FAIL held_frame: done=%b bytes %0d required 1 16", seen, cap_a.size());
    end
    for (int i = 0; i < 16 && i < cap_a.size(); i++) begin
      vectors++;
      if (cap_a[i] !== model_a[32 + i]) begin
        miscompares++;
        $display("FAIL held_byte[%0d]: got %h required %h", i, cap_a[i], model_a[32 + i]);
      end
    end
  endtask

  task automatic test_bad_line();
    bit seen;
    int vb = 0;
    settle();
    start_bb(1'b1, 3);
    vectors++;
    if (start_err_b !== 1'b1 || busy_b !== 1'b0) begin
      miscompares++;
      $display("FAIL badline_pulse: start_err=%b busy=%b required 1 0", start_err_b, busy_b);
    end
    step();
    vectors++;
    if (start_err_b !== 1'b0) begin
      miscompares++;
      $display("FAIL badline_width: start_err=%b required 0", start_err_b);
    end
    repeat (5) begin
      if (send_valid_b || busy_b) vb++;
      step();
    end
    vectors++;
    if (vb != 0) begin
      miscompares++;
      $display("FAIL badline_idle: active cycles %0d required 0", vb);
    end
    write_b(10, 8'($urandom));
    write_b(14, 8'($urandom));
    write_b(15, 8'($urandom));
    for (int k = 0; k < 2; k++) begin
      settle();
      start_bb(k == 0, 2);
      wait_frame_b(500, seen);
      vectors++;
      if (!seen || cap_b.size() != (k == 0 ? 5 : 15)) begin
        miscompares++;
        $display("FAIL b_frame%0d: done=%b bytes %0d required 1 %0d", k, seen, cap_b.size(), k == 0 ? 5 : 15);
      end
      for (int i = 0; i < cap_b.size() && i < 15; i++) begin
        vectors++;
        if (cap_b[i] !== model_b[(k == 0 ? 10 : 0) + i]) begin
          miscompares++;
          $display("FAIL b_frame%0d_byte[%0d]: got %h required %h", k, i, cap_b[i], model_b[(k == 0 ? 10 : 0) + i]);
        end
      end
    end
  endtask

  task automatic test_refresh();
    bit seen, bok, ok;
    logic [7:0] old5, e;
    int act = 0;
    settle();
    start_a(1'b0, 0);
    wait_bytes_a(10, ok);
    old5 = model_a[5];
    write_a(5, ~old5);
    wait_frame_a(1000, seen, bok);
    vectors++;
    if (!seen || cap_a.size() != 64) begin
      miscompares++;
      $display("FAIL refresh_first: done=%b bytes %0d required 1 64", seen, cap_a.size());
    end
    for (int i = 0; i < 64 && i < cap_a.size(); i++) begin
      e = (i == 5) ? old5 : model_a[i];
      vectors++;
      if (cap_a[i] !== e) begin
        miscompares++;
        $display("FAIL refresh_first_byte[%0d]: got %h required %h", i, cap_a[i], e);
      end
    end
    cap_a.delete();
    step();
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy) act++;
    end
`ifdef OLED_STREAMER_AUTOREFRESH_EN
    vectors++;
    if (act == 0) begin
      miscompares++;
      $display("FAIL autorefresh_launch: busy cycles %0d required >0", act);
    end
    wait_frame_a(1000, seen, bok);
    vectors++;
    if (!seen || cap_a.size() != 64) begin
      miscompares++;
      $display("FAIL autorefresh_frame: done=%b bytes %0d required 1 64", seen, cap_a.size());
    end
    for (int i = 0; i < 64 && i < cap_a.size(); i++) begin
      vectors++;
      if (cap_a[i] !== model_a[i]) begin
        miscompares++;
        $display("FAIL autorefresh_byte[%0d]: got %h required %h", i, cap_a[i], model_a[i]);
      end
    end
`else
    vectors++;
    if (act != 0) begin
      miscompares++;
      $display("FAIL no_autorefresh: busy cycles %0d required 0", act);
    end
`endif
  endtask

  task automatic test_reset_midframe();
    bit seen, bok, ok;
    int fd0;
    settle();
    fd0 = fd_a;
    start_a(1'b0, 0);
    wait_bytes_a(10, ok);
    rst = 1'b1;
    step();
    vectors++;
    if (send_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_drop: valid=%b busy=%b required 0 0", send_valid, busy);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) model_a[i] = 8'h20;
    for (int i = 0; i < 15; i++) model_b[i] = 8'h20;
    repeat (6) step();
    vectors++;
    if (fd_a != fd0 || !ok) begin
      miscompares++;
      $display("FAIL midreset_done: frame_done x%0d reached10=%b required x0 1", fd_a - fd0, ok);
    end
    settle();
    start_a(1'b0, 0);
    wait_frame_a(1000, seen, bok);
    vectors++;
    if (!seen || cap_a.size() != 64) begin
      miscompares++;
      $display("FAIL midreset_frame: done=%b bytes %0d required 1 64", seen, cap_a.size());
    end
    for (int i = 0; i < 64 && i < cap_a.size(); i++) begin
      vectors++;
      if (cap_a[i] !== model_a[i]) begin
        miscompares++;
        $display("FAIL midreset_byte[%0d]: got %h required %h", i, cap_a[i], model_a[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; mode = 1'b0; line_sel = '0;
    wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; start_b = 1'b0; mode_b = 1'b0; line_sel_b = '0;
    send_done = 1'b0;
    send_done_b = 1'b0;
    for (int i = 0; i < 64; i++) model_a[i] = 8'h20;
    for (int i = 0; i < 15; i++) model_b[i] = 8'h20;
    test_reset();
    test_full();
    test_line();
    test_back_to_back();
    test_done_held();
    test_bad_line();
    test_refresh();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
